// File: rtl/dkong3_vram_cpu_if.sv
// CPU-side master for the background-tile VRAM port.
// Writes are posted through a small FIFO so the CPU rarely stalls. Reads stall
// the CPU through WAITn until the data returns. An access starts only while the
// registered VRAM busy flag reports a free window. Once started, an access
// always runs to completion.
//
// Ports:
//   I_CLK_24M       single clock for all state
//   I_RESET         synchronous, active-high reset
//   I_CPU_AB/DB     CPU VRAM offset / write data
//   I_CPU_WR_REQ    write request, one-cycle qualifier
//   I_CPU_RD_REQ    read request, one-cycle qualifier
//   O_CPU_DB        read data, held until the next read completes
//   O_CPU_RD_VALID  one-cycle pulse when O_CPU_DB updates
//   O_CPU_WAITn     low = CPU must stall and issue no new requests
//   I_VRAMBUSYn     VRAM scan-window flag; low = no access may start
//   I_VRAM_DB       VRAM read data
//   O_VRAM_AB/DB    VRAM address / write data (DB is 0 when not writing)
//   O_VRAM_WRn/RDn  active-low write / read strobes
//   O_FIFO_LEVEL    posted writes outstanding
module dkong3_vram_cpu_if #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STROBE_CYCLES = 4
) (
  input  logic       I_CLK_24M,
  input  logic       I_RESET,
  input  logic [9:0] I_CPU_AB,
  input  logic [7:0] I_CPU_DB,
  input  logic       I_CPU_WR_REQ,
  input  logic       I_CPU_RD_REQ,
  output logic [7:0] O_CPU_DB,
  output logic       O_CPU_RD_VALID,
  output logic       O_CPU_WAITn,
  input  logic       I_VRAMBUSYn,
  input  logic [7:0] I_VRAM_DB,
  output logic [9:0] O_VRAM_AB,
  output logic [7:0] O_VRAM_DB,
  output logic       O_VRAM_WRn,
  output logic       O_VRAM_RDn,
  output logic [3:0] O_FIFO_LEVEL
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(STROBE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STROBE_CYCLES - 1);
  localparam logic [3:0] LevelFull = 4'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StWrSetup,
    StWrStrb,
    StWrHold,
    StRdSetup,
    StRdStrb,
    StRdDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q;

  logic [9:0]      fifo_ab_q [FIFO_DEPTH];
  logic [7:0]      fifo_db_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]      level_q, level_d;

  logic            rd_pending_q, rd_pending_d;
  logic [9:0]      rd_addr_q;

  logic [9:0]      vram_ab_q, vram_ab_d;
  logic [7:0]      vram_db_q, vram_db_d;
  logic            wrn_q, wrn_d;
  logic            rdn_q, rdn_d;
  logic [7:0]      cpu_db_q, cpu_db_d;
  logic            rd_valid_q, rd_valid_d;
  logic            waitn_q, waitn_d;

  logic wr_acc, rd_acc, push, pop, fifo_empty, strb_last;

  // Requests are only taken while WAITn is high; full FIFO forces WAITn low,
  // so a push can never overflow.
  assign wr_acc     = I_CPU_WR_REQ && waitn_q;
  assign rd_acc     = I_CPU_RD_REQ && waitn_q;
  assign push       = wr_acc;
  assign pop        = (state_q == StWrHold);
  assign fifo_empty = (level_q == 4'd0);
  assign strb_last  = (cnt_q == CntLast);

  // State register
  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; busy_q only matters when leaving idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (busy_q && !fifo_empty) begin
          state_d = StWrSetup;
        end else if (busy_q && rd_pending_q) begin
          state_d = StRdSetup;
        end
      end
      StWrSetup: state_d = StWrStrb;
      StWrStrb: begin
        if (strb_last) state_d = StWrHold;
        else           cnt_d   = cnt_q + 1'b1;
      end
      StWrHold:  state_d = StIdle;
      StRdSetup: state_d = StRdStrb;
      StRdStrb: begin
        if (strb_last) state_d = StRdDone;
        else           cnt_d   = cnt_q + 1'b1;
      end
      StRdDone:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic: decoded from the next state so the registered strobes line
  // up exactly with the state register and never glitch.
  always_comb begin
    vram_ab_d  = vram_ab_q;
    vram_db_d  = 8'h00;
    wrn_d      = 1'b1;
    rdn_d      = 1'b1;
    rd_valid_d = 1'b0;
    cpu_db_d   = cpu_db_q;
    unique case (state_d)
      StWrSetup, StWrStrb, StWrHold: begin
        vram_ab_d = fifo_ab_q[rd_ptr_q];
        vram_db_d = fifo_db_q[rd_ptr_q];
        wrn_d     = (state_d != StWrStrb);
      end
      StRdSetup, StRdStrb: begin
        vram_ab_d = rd_addr_q;
        rdn_d     = (state_d != StRdStrb);
      end
      StRdDone:  rd_valid_d = 1'b1;
      default:   ;
    endcase
    if (state_q == StRdStrb && strb_last) begin
      cpu_db_d = I_VRAM_DB;
    end
  end

  // Level, read-pending and WAITn bookkeeping
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 4'd1;
      2'b01:   level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase

    rd_pending_d = rd_pending_q;
    if (state_q == StRdDone) rd_pending_d = 1'b0;
    if (rd_acc)              rd_pending_d = 1'b1;

    waitn_d = !(rd_pending_d || (level_d == LevelFull));
  end

  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET) begin
      busy_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= 4'd0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= 10'd0;
      vram_ab_q    <= 10'd0;
      vram_db_q    <= 8'h00;
      wrn_q        <= 1'b1;
      rdn_q        <= 1'b1;
      cpu_db_q     <= 8'h00;
      rd_valid_q   <= 1'b0;
      waitn_q      <= 1'b1;
    end else begin
      busy_q       <= I_VRAMBUSYn;
      level_q      <= level_d;
      rd_pending_q <= rd_pending_d;
      vram_ab_q    <= vram_ab_d;
      vram_db_q    <= vram_db_d;
      wrn_q        <= wrn_d;
      rdn_q        <= rdn_d;
      cpu_db_q     <= cpu_db_d;
      rd_valid_q   <= rd_valid_d;
      waitn_q      <= waitn_d;
      if (push) wr_ptr_q  <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q  <= rd_ptr_q + 1'b1;
      if (rd_acc) rd_addr_q <= I_CPU_AB;
    end
  end

  // Payload storage needs no reset; level_q qualifies every entry.
  always_ff @(posedge I_CLK_24M) begin
    if (push) begin
      fifo_ab_q[wr_ptr_q] <= I_CPU_AB;
      fifo_db_q[wr_ptr_q] <= I_CPU_DB;
    end
  end

  assign O_VRAM_AB      = vram_ab_q;
  assign O_VRAM_DB      = vram_db_q;
  assign O_VRAM_WRn     = wrn_q;
  assign O_VRAM_RDn     = rdn_q;
  assign O_CPU_DB       = cpu_db_q;
  assign O_CPU_RD_VALID = rd_valid_q;
  assign O_CPU_WAITn    = waitn_q;
  assign O_FIFO_LEVEL   = level_q;

endmodule

// File: tb/tb_dkong3_vram_cpu_if.sv
// Bench for dkong3_vram_cpu_if: directed scenarios plus randomized traffic.
// The reference is a memory-level model: accepted writes go into an expected
// write queue and a shadow memory; a read expects the shadow value at accept
// time. A VRAM model answers the DUT strobes and a monitor checks every strobe.
module tb_dkong3_vram_cpu_if;

  localparam int unsigned Depth  = 4;
  localparam int unsigned Strobe = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] cpu_ab;
  logic [7:0] cpu_db;
  logic       wr_req, rd_req;
  logic [7:0] cpu_rdata;
  logic       rd_valid, waitn;
  logic       busy;
  logic [7:0] vram_rdata;
  logic [9:0] vram_ab;
  logic [7:0] vram_db;
  logic       vram_wrn, vram_rdn;
  logic [3:0] level;

  always #5 clk = ~clk;

  dkong3_vram_cpu_if #(
    .FIFO_DEPTH    (Depth),
    .STROBE_CYCLES (Strobe)
  ) u_dut (
    .I_CLK_24M      (clk),
    .I_RESET        (rst),
    .I_CPU_AB       (cpu_ab),
    .I_CPU_DB       (cpu_db),
    .I_CPU_WR_REQ   (wr_req),
    .I_CPU_RD_REQ   (rd_req),
    .O_CPU_DB       (cpu_rdata),
    .O_CPU_RD_VALID (rd_valid),
    .O_CPU_WAITn    (waitn),
    .I_VRAMBUSYn    (busy),
    .I_VRAM_DB      (vram_rdata),
    .O_VRAM_AB      (vram_ab),
    .O_VRAM_DB      (vram_db),
    .O_VRAM_WRn     (vram_wrn),
    .O_VRAM_RDn     (vram_rdn),
    .O_FIFO_LEVEL   (level)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Reference state
  logic [7:0]  vram_mem [1024];
  logic [7:0]  shadow   [1024];
  logic [17:0] exp_wr_q [$];
  logic [17:0] exp_rd_q [$];
  int n_wr = 0;
  int n_rd = 0;

  assign vram_rdata = !vram_rdn ? vram_mem[vram_ab] : 8'h00;

  // Busy value seen at the last three rising edges; [2] is the value the
  // DUT's registered busy flag held when it left idle for a given strobe.
  logic [2:0] busy_hist = 3'b000;
  always @(posedge clk) busy_hist <= {busy_hist[1:0], busy};

  // Strobe monitor / VRAM model
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          wr_done = 0;
  int          rd_valid_cnt = 0;
  logic [9:0]  prev_ab = 10'd0;
  logic [7:0]  prev_db = 8'h00;
  logic [17:0] fr;

  initial begin
    for (int i = 0; i < 1024; i++) vram_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_cnt = 0;
        rd_cnt = 0;
      end else begin
        if (!vram_wrn) begin
          if (wr_cnt == 0) check("wr_queue_nonempty", 32'(exp_wr_q.size() != 0), 1);
          if (exp_wr_q.size() != 0) begin
            fr = exp_wr_q[0];
            if (wr_cnt == 0) begin
              check("wr_busy_gate", 32'(busy_hist[2]), 1);
              check("wr_setup_ab", 32'(prev_ab), 32'(fr[17:8]));
              check("wr_setup_db", 32'(prev_db), 32'(fr[7:0]));
            end
            check("wr_strb_ab", 32'(vram_ab), 32'(fr[17:8]));
            check("wr_strb_db", 32'(vram_db), 32'(fr[7:0]));
          end
          vram_mem[vram_ab] = vram_db;
          wr_cnt++;
        end else if (wr_cnt > 0) begin
          check("wr_width", 32'(wr_cnt), Strobe);
          if (exp_wr_q.size() != 0) begin
            fr = exp_wr_q[0];
            check("wr_hold_ab", 32'(vram_ab), 32'(fr[17:8]));
            check("wr_hold_db", 32'(vram_db), 32'(fr[7:0]));
            void'(exp_wr_q.pop_front());
          end
          wr_done++;
          wr_cnt = 0;
        end

        if (!vram_rdn) begin
          if (rd_cnt == 0) begin
            check("rd_after_writes", 32'(exp_wr_q.size()), 0);
            check("rd_busy_gate", 32'(busy_hist[2]), 1);
            check("rd_queue_nonempty", 32'(exp_rd_q.size() != 0), 1);
          end
          if (exp_rd_q.size() != 0) begin
            fr = exp_rd_q[0];
            check("rd_ab", 32'(vram_ab), 32'(fr[17:8]));
          end
          check("rd_vram_db_zero", 32'(vram_db), 0);
          rd_cnt++;
        end else if (rd_cnt > 0) begin
          check("rd_width", 32'(rd_cnt), Strobe);
          rd_cnt = 0;
        end

        if (rd_valid) begin
          check("rd_valid_expected", 32'(exp_rd_q.size() != 0), 1);
          if (exp_rd_q.size() != 0) begin
            fr = exp_rd_q[0];
            check("rd_data", 32'(cpu_rdata), 32'(fr[7:0]));
            void'(exp_rd_q.pop_front());
          end
          rd_valid_cnt++;
        end
      end
      prev_ab = vram_ab;
      prev_db = vram_db;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a cycle; the model accepts it under the same
  // rule the CPU sees: only while WAITn is high.
  task automatic do_req(input logic wr, input logic rd, input logic [9:0] ab,
                        input logic [7:0] db);
    cpu_ab = ab;
    cpu_db = db;
    wr_req = wr;
    rd_req = rd;
    if (waitn) begin
      if (wr) begin
        exp_wr_q.push_back({ab, db});
        shadow[ab] = db;
        n_wr++;
      end
      if (rd) begin
        exp_rd_q.push_back({ab, shadow[ab]});
        n_rd++;
      end
    end
    tick();
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (n < budget && !done) begin
      done = (exp_wr_q.size() == 0) && (exp_rd_q.size() == 0) && (level == 4'd0) &&
             waitn && vram_wrn && vram_rdn;
      if (!done) begin
        tick();
        n++;
      end
    end
    check(tag, 32'(done), 1);
  endtask

  int   snap;
  int   n;
  logic early;
  int   r;
  logic [9:0] ab;

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
    rst = 1'b1;
    busy = 1'b1;
    cpu_ab = 10'd0;
    cpu_db = 8'h00;
    wr_req = 1'b0;
    rd_req = 1'b0;

    // Reset and idle
    repeat (3) tick();
    check("rst_wrn", 32'(vram_wrn), 1);
    check("rst_rdn", 32'(vram_rdn), 1);
    check("rst_waitn", 32'(waitn), 1);
    check("rst_level", 32'(level), 0);
    check("rst_vram_db", 32'(vram_db), 0);
    check("rst_vram_ab", 32'(vram_ab), 0);
    check("rst_cpu_db", 32'(cpu_rdata), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single write with busy high
    do_req(1'b1, 1'b0, 10'h155, 8'hA5);
    check("single_level_after_push", 32'(level), 1);
    n = 0;
    while (exp_wr_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("single_done", 32'(exp_wr_q.size()), 0);
    check("single_level_after_pop", 32'(level), 0);
    check("single_mem", 32'(vram_mem[10'h155]), 32'h0A5);
    tick();
    check("idle_vram_db_zero", 32'(vram_db), 0);
    check("idle_ab_held", 32'(vram_ab), 32'h155);

    // Busy gating: fill the FIFO while the window is closed
    busy = 1'b0;
    repeat (2) tick();
    snap = wr_done;
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 10'(10'h040 + i), 8'(8'h10 + i));
    check("gate_level_full", 32'(level), Depth);
    check("gate_waitn_full", 32'(waitn), 0);
    do_req(1'b1, 1'b0, 10'h3FF, 8'hEE);
    repeat (4) tick();
    check("gate_5th_ignored", 32'(level), Depth);
    check("gate_no_strobe", 32'(wr_done - snap), 0);
    busy = 1'b1;
    n = 0;
    while (level != 4'd3 && n < 30) begin
      tick();
      n++;
    end
    check("gate_first_pop", 32'(level), 3);
    check("gate_waitn_after_pop", 32'(waitn), 1);
    drain("gate_drain", 100);
    check("gate_strobes", 32'(wr_done - snap), 4);
    check("gate_ignored_not_written", 32'(vram_mem[10'h3FF]), 0);

    // Read-after-write in one cycle
    snap = rd_valid_cnt;
    do_req(1'b1, 1'b1, 10'h020, 8'h3C);
    check("raw_waitn_low", 32'(waitn), 0);
    n = 0;
    early = 1'b0;
    while (rd_valid_cnt == snap && n < 40) begin
      if (waitn) early = 1'b1;
      tick();
      n++;
    end
    check("raw_waitn_held_low", 32'(early), 0);
    check("raw_valid_once", 32'(rd_valid_cnt - snap), 1);
    check("raw_cpu_db", 32'(cpu_rdata), 32'h03C);
    check("raw_waitn_back", 32'(waitn), 1);
    check("raw_valid_pulse_ends", 32'(rd_valid), 0);
    repeat (3) tick();
    check("raw_no_second_valid", 32'(rd_valid_cnt - snap), 1);

    // Busy drops during the second strobe cycle
    do_req(1'b1, 1'b0, 10'h0A0, 8'h5A);
    do_req(1'b1, 1'b0, 10'h0A1, 8'hC3);
    n = 0;
    while (vram_wrn && n < 20) begin
      tick();
      n++;
    end
    check("drop_strobe_seen", 32'(vram_wrn), 0);
    tick();
    busy = 1'b0;
    n = 0;
    while (exp_wr_q.size() > 1 && n < 20) begin
      tick();
      n++;
    end
    snap = wr_done;
    repeat (12) tick();
    check("drop_second_waits", 32'(wr_done - snap), 0);
    check("drop_level_one", 32'(level), 1);
    busy = 1'b1;
    drain("drop_drain", 60);
    check("drop_second_written", 32'(vram_mem[10'h0A1]), 32'h0C3);

    // Reset in the middle of a read strobe
    snap = rd_valid_cnt;
    do_req(1'b0, 1'b1, 10'h0A0, 8'h00);
    n = 0;
    while (vram_rdn && n < 20) begin
      tick();
      n++;
    end
    check("rstrd_strobe_seen", 32'(vram_rdn), 0);
    rst = 1'b1;
    exp_rd_q.delete();
    n_rd--;
    tick();
    check("rstrd_rdn", 32'(vram_rdn), 1);
    check("rstrd_waitn", 32'(waitn), 1);
    check("rstrd_level", 32'(level), 0);
    check("rstrd_valid", 32'(rd_valid), 0);
    rst = 1'b0;
    repeat (8) tick();
    check("rstrd_no_valid", 32'(rd_valid_cnt - snap), 0);
    check("rstrd_rdn_idle", 32'(vram_rdn), 1);

    // Randomized traffic with random busy windows
    for (int i = 0; i < 600; i++) begin
      busy = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      ab = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
      if (waitn && r < 6) begin
        do_req((r < 3) || (r == 5), (r == 3) || (r == 4) || (r == 5), ab, 8'($urandom));
      end else begin
        tick();
      end
    end
    busy = 1'b1;
    drain("rand_drain", 600);
    check("total_writes", 32'(wr_done), 32'(n_wr));
    check("total_reads", 32'(rd_valid_cnt), 32'(n_rd));
    check("final_vram_db_zero", 32'(vram_db), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
